// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load-store unit between execute and writeback.
//
// Takes the effective address (rs1 + imm) plus store data and funct3 of a
// load/store, runs one outstanding request/grant/response transaction on the
// data-memory port, produces byte enables and lane-replicated store data, and
// aligns/extends load data. Results leave as a one-cycle writeback pulse or a
// one-cycle exception pulse. Every output is driven from a flop.
//
// Ports
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   req_*               execute-stage request (valid/ready, we, funct3, addr,
//                       wdata, rd)
//   dmem_*              data-memory port (req/gnt, rvalid/rdata/err)
//   wb_valid_o/rd/data  load writeback pulse with destination and data
//   exc_valid_o/cause/addr  exception pulse: 0 ld-misaligned, 1 st-misaligned,
//                       2 ld-fault, 3 st-fault; addr is the byte address
// -----------------------------------------------------------------------------
module lsu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        exc_valid_o,
  output logic [1:0]  exc_cause_o,
  output logic [31:0] exc_addr_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Half needs bit 0 clear, word needs both low bits clear.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = a[0];
      default: is_misaligned = (a != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    byte_en = 4'b0001 << a;
      2'd1:    byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicating the operand across lanes lets memory pick by byte enable.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    store_data = {4{d[7:0]}};
      2'd1:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend per funct3.
  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (f3[1:0])
      2'd0:    load_data = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    load_data = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_data = d;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    exc_valid_d  = 1'b0;
    exc_cause_d  = exc_cause_q;
    exc_addr_d   = exc_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          rd_d     = req_rd_i;
          if (is_misaligned(req_funct3_i[1:0], req_addr_i[1:0])) begin
            // Reported straight from IDLE; memory is never touched.
            state_d     = ST_IDLE;
            exc_valid_d = 1'b1;
            exc_cause_d = {1'b0, req_we_i};
            exc_addr_d  = req_addr_i;
          end else begin
            state_d      = ST_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = req_we_i;
            dmem_addr_d  = {req_addr_i[31:2], 2'b00};
            dmem_be_d    = byte_en(req_funct3_i[1:0], req_addr_i[1:0]);
            dmem_wdata_d = store_data(req_funct3_i[1:0], req_wdata_i);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          state_d    = ST_WAIT;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = ST_IDLE;
          if (dmem_err_i) begin
            exc_valid_d = 1'b1;
            exc_cause_d = {1'b1, we_q};
            exc_addr_d  = addr_q;
          end else if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data(funct3_q, addr_q[1:0], dmem_rdata_i);
          end else begin
            wb_valid_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= 2'd0;
      exc_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      exc_valid_q  <= exc_valid_d;
      exc_cause_q  <= exc_cause_d;
      exc_addr_q   <= exc_addr_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_be_o    = dmem_be_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign exc_valid_o  = exc_valid_q;
  assign exc_cause_o  = exc_cause_q;
  assign exc_addr_o   = exc_addr_q;

endmodule
